i2c_master_ctrl: RTL

I2C_MASTER_CTRL -- requirements
Module: i2c_master_ctrl

---
 rtl/i2c_pkg.sv | 37 +++
 rtl/i2c_clk_div.sv | 31 +++
 rtl/i2c_master_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master controller.
package i2c_pkg;

  localparam int CMD_W   = 3;
  localparam int PHASE_W = 2;

  typedef enum logic [CMD_W-1:0] {
    CMD_START    = 3'd0,
    CMD_STOP     = 3'd1,
    CMD_WRITE    = 3'd2,
    CMD_READ_ACK = 3'd3,
    CMD_READ_NAK = 3'd4
  } i2c_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_STOP,
    ST_WBIT,
    ST_WACK,
    ST_RBIT,
    ST_RACK
  } i2c_state_t;

  typedef logic [PHASE_W-1:0] phase_t;

  localparam phase_t P0 = 2'd0;
  localparam phase_t P1 = 2'd1;
  localparam phase_t P2 = 2'd2;
  localparam phase_t P3 = 2'd3;

  // Codes 5..7 are not commands.
  function automatic logic cmd_legal(input i2c_cmd_t c);
    return c <= CMD_READ_NAK;
  endfunction

endpackage

// File: rtl/i2c_clk_div.sv
// Quarter-period tick generator; holds at 0 when disabled, freezes on stretch.
module i2c_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic freeze_i,
  output logic tick_o
);
  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && !freeze_i && (cnt_q == LAST);

  // Next count: cleared when idle, held while the responder stretches SCL.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i)          cnt_d = '0;
    else if (!freeze_i) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-master I2C byte-level controller: START/STOP/WRITE/READ commands,
// open-drain SCL/SDA with clock-stretching support.
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int CLK_DIV        = 4,
  parameter int I2C_DATA_WIDTH = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  i2c_cmd_t                  cmd_i,
  input  logic [I2C_DATA_WIDTH-1:0] wdata_i,
  output logic                      rsp_valid_o,
  output logic [I2C_DATA_WIDTH-1:0] rdata_o,
  output logic                      ack_o,
  output logic                      err_o,
  output logic                      bus_busy_o,
  output logic                      scl_o,
  output logic                      sda_o,
  input  logic                      scl_i,
  input  logic                      sda_i
);
  localparam int W  = I2C_DATA_WIDTH;
  localparam int BW = (W > 2) ? $clog2(W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);

  i2c_state_t    state_q, state_d;
  phase_t        phase_q, phase_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [W-1:0]  shreg_q, shreg_d;
  logic [W-1:0]  rdata_q, rdata_d;
  logic          nak_q, nak_d;
  logic          scl_q, scl_d, sda_q, sda_d;
  logic          busy_q, busy_d;
  logic          rsp_q, rsp_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic          tick;

  i2c_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (state_q != ST_IDLE),
    .freeze_i (scl_q && !scl_i),
    .tick_o   (tick)
  );

  assign cmd_ready_o = !rst_i && (state_q == ST_IDLE);
  assign rsp_valid_o = rsp_q;
  assign rdata_o     = rdata_q;
  assign ack_o       = ack_q;
  assign err_o       = err_q;
  assign bus_busy_o  = busy_q;
  assign scl_o       = scl_q;
  assign sda_o       = sda_q;

  // Next-state, line levels and response; line registers lag the phase by one
  // cycle, so SDA edges in data slots always land while SCL is already low.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    nak_d   = nak_q;
    scl_d   = scl_q;
    sda_d   = sda_q;
    busy_d  = busy_q;
    rsp_d   = 1'b0;
    ack_d   = ack_q;
    err_d   = err_q;
    rdata_d = rdata_q;

    case (state_q)
      ST_START: begin
        case (phase_q)
          P0:      sda_d = 1'b1;
          P1:      scl_d = 1'b1;
          P2:      sda_d = 1'b0;
          default: scl_d = 1'b0;
        endcase
      end
      ST_STOP: begin
        case (phase_q)
          P0: begin
            scl_d = 1'b0;
            sda_d = 1'b0;
          end
          P1:      scl_d = 1'b1;
          P2:      sda_d = 1'b1;
          default: ;
        endcase
      end
      ST_WBIT, ST_WACK, ST_RBIT, ST_RACK: begin
        scl_d = (phase_q == P1) || (phase_q == P2);
        if (phase_q == P0) begin
          if (state_q == ST_WBIT)      sda_d = shreg_q[W-1];
          else if (state_q == ST_RACK) sda_d = nak_q;
          else                         sda_d = 1'b1;
        end
      end
      default: ;
    endcase

    if (state_q == ST_IDLE) begin
      phase_d = P0;
      bit_d   = '0;
      if (cmd_valid_i && cmd_ready_o) begin
        if (!cmd_legal(cmd_i) || (cmd_i != CMD_START && !busy_q)) begin
          rsp_d = 1'b1;
          err_d = 1'b1;
        end else begin
          case (cmd_i)
            CMD_START: state_d = ST_START;
            CMD_STOP:  state_d = ST_STOP;
            CMD_WRITE: begin
              state_d = ST_WBIT;
              shreg_d = wdata_i;
            end
            default: begin
              state_d = ST_RBIT;
              nak_d   = (cmd_i == CMD_READ_NAK);
            end
          endcase
        end
      end
    end else if (tick) begin
      phase_d = phase_q + 1'b1;
      // Sample on the last cycle of the SCL-high window.
      if (phase_q == P2 && (state_q == ST_RBIT || state_q == ST_WACK))
        shreg_d = {shreg_q[W-2:0], sda_i};
      if (phase_q == P3) begin
        case (state_q)
          ST_WBIT: begin
            shreg_d = shreg_q << 1;
            if (bit_q == LAST_BIT) state_d = ST_WACK;
            else                   bit_d   = bit_q + 1'b1;
          end
          ST_RBIT: begin
            if (bit_q == LAST_BIT) state_d = ST_RACK;
            else                   bit_d   = bit_q + 1'b1;
          end
          default: begin
            state_d = ST_IDLE;
            rsp_d   = 1'b1;
            err_d   = 1'b0;
            if (state_q == ST_START) busy_d  = 1'b1;
            if (state_q == ST_STOP)  busy_d  = 1'b0;
            if (state_q == ST_WACK)  ack_d   = ~shreg_q[0];
            if (state_q == ST_RACK)  rdata_d = shreg_q;
          end
        endcase
      end
    end
  end

  // State registers; reset releases both lines immediately, no STOP is sent.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      phase_q <= P0;
      bit_q   <= '0;
      shreg_q <= '0;
      nak_q   <= 1'b0;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
      busy_q  <= 1'b0;
      rsp_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      nak_q   <= nak_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
      busy_q  <= busy_d;
      rsp_q   <= rsp_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
